norm_unit: RTL and testbench

NORM_UNIT -- requirements
Module: norm_unit

---
 rtl/norm_unit_pkg.sv | 16 +
 rtl/norm_unit.sv | 108 ++++++++++
 tb/tb_norm_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/norm_unit_pkg.sv
// Shared constants for the normalizer: default data width, FSM state
// encodings and operating-mode values.
package norm_unit_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic NORM_LOG = 1'b0;
    localparam logic NORM_ARI = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } norm_state_e;

endpackage

// File: rtl/norm_unit.sv
// Iterative normalizer: shifts the operand left one bit per cycle until the
// leading-zero (logical) or redundant-sign (arithmetic) run is removed.
module norm_unit
    import norm_unit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             zero
);

    localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_SIGN = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    norm_state_e      r_state;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic             r_zero;
    logic             r_mode;

    norm_state_e      w_state_next;
    logic [WIDTH-1:0] w_data_next;
    logic [CW-1:0]    w_count_next;
    logic             w_zero_next;
    logic             w_mode_next;
    logic             w_normalized;
    logic             w_in_zero;
    logic             w_in_ones;

    assign w_in_zero    = (data_in == '0);
    assign w_in_ones    = (&data_in);
    // Arithmetic operands are normalized once the top two bits disagree.
    assign w_normalized = (r_mode == NORM_LOG) ? r_data[WIDTH-1]
                                               : (r_data[WIDTH-1] ^ r_data[WIDTH-2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
            r_mode  <= NORM_LOG;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_count <= w_count_next;
            r_zero  <= w_zero_next;
            r_mode  <= w_mode_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_count_next = r_count;
        w_zero_next  = r_zero;
        w_mode_next  = r_mode;
        case (r_state)
            SHIFT: begin
                if (w_normalized) begin
                    w_state_next = DONE;
                end else begin
                    w_data_next  = {r_data[WIDTH-2:0], 1'b0};
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_mode_next  = mode;
                    w_data_next  = data_in;
                    w_count_next = '0;
                    w_zero_next  = 1'b0;
                    w_state_next = SHIFT;
                    // Operands with no terminating bit would never normalize; resolve them here.
                    if (w_in_zero) begin
                        w_data_next  = '0;
                        w_zero_next  = 1'b1;
                        w_count_next = (mode == NORM_LOG) ? CNT_FULL : CNT_SIGN;
                        w_state_next = DONE;
                    end else if ((mode == NORM_ARI) && w_in_ones) begin
                        w_data_next  = MSB_ONLY;
                        w_count_next = CNT_SIGN;
                        w_state_next = DONE;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    assign busy    = (r_state == SHIFT);
    assign done    = (r_state == DONE);
    assign o_data  = r_data;
    assign o_count = r_count;
    assign zero    = r_zero;

endmodule

// File: tb/tb_norm_unit.sv
// Directed bench for norm_unit (WIDTH=32): hand-computed results, latency,
// busy occupancy, mid-operation start and reset, and back-to-back accepts.
module tb_norm_unit;
    import norm_unit_pkg::*;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start   = 1'b0;
    logic          mode    = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  o_data;
    logic [CW-1:0] o_count;
    logic          zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    norm_unit #(.WIDTH(W), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .o_data  (o_data),
        .o_count (o_count),
        .zero    (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one edge, then scrambles mode/data while the unit works.
    task automatic accept(input logic m, input logic [W-1:0] d);
        start   = 1'b1;
        mode    = m;
        data_in = d;
        tick();
        start   = 1'b0;
        mode    = ~m;
        data_in = ~d;
    endtask

    task automatic run(input string tag, input int exp_lat, input int exp_busy);
        int cyc = 0;
        int nb  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (busy === 1'b1) nb++;
        end
        chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    task automatic result(input string tag, input logic [W-1:0] e_data,
                          input int e_count, input logic e_zero);
        chk({tag, ".done"},  32'(done), 32'd1);
        chk({tag, ".data"},  o_data, e_data);
        chk({tag, ".count"}, 32'(o_count), 32'(e_count));
        chk({tag, ".zero"},  32'(zero), 32'(e_zero));
        $display("txn %s: data=0x%08h count=%0d zero=%0b", tag, o_data, o_count, zero);
    endtask

    task automatic idle_hold(input string tag, input logic [W-1:0] e_data, input int e_count);
        tick();
        chk({tag, ".idle_done"},  32'(done), 32'd0);
        chk({tag, ".idle_busy"},  32'(busy), 32'd0);
        chk({tag, ".hold_data"},  o_data, e_data);
        chk({tag, ".hold_count"}, 32'(o_count), 32'(e_count));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.data",  o_data, 32'd0);
        chk("rst.count", 32'(o_count), 32'd0);
        chk("rst.zero",  32'(zero), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst.busy", 32'(busy), 32'd0);

        accept(NORM_LOG, 32'h0000_1000);
        chk("log_1000.busy0", 32'(busy), 32'd1);
        run("log_1000", 20, 19);
        result("log_1000", 32'h8000_0000, 19, 1'b0);
        idle_hold("log_1000", 32'h8000_0000, 19);

        accept(NORM_LOG, 32'h0000_0000);
        run("log_zero", 0, 0);
        result("log_zero", 32'h0000_0000, 32, 1'b1);
        idle_hold("log_zero", 32'h0000_0000, 32);
        chk("log_zero.hold_zero", 32'(zero), 32'd1);

        accept(NORM_LOG, 32'h8000_0000);
        chk("log_msb.busy0", 32'(busy), 32'd1);
        run("log_msb", 1, 0);
        result("log_msb", 32'h8000_0000, 0, 1'b0);
        tick();

        accept(NORM_ARI, 32'hFFFF_F000);
        run("ari_neg", 20, 19);
        result("ari_neg", 32'h8000_0000, 19, 1'b0);
        tick();

        accept(NORM_ARI, 32'hFFFF_FFFF);
        run("ari_ones", 0, 0);
        result("ari_ones", 32'h8000_0000, 31, 1'b0);
        tick();

        accept(NORM_ARI, 32'h0000_0000);
        run("ari_zero", 0, 0);
        result("ari_zero", 32'h0000_0000, 31, 1'b1);
        tick();

        accept(NORM_ARI, 32'h0000_0FFF);
        run("ari_pos", 20, 19);
        result("ari_pos", 32'h7FF8_0000, 19, 1'b0);
        tick();

        // Second request arrives while shifting and must be ignored.
        accept(NORM_LOG, 32'h0000_0001);
        tick();
        tick();
        tick();
        start   = 1'b1;
        mode    = NORM_LOG;
        data_in = 32'h8000_0000;
        tick();
        start   = 1'b0;
        run("log_one", 28, 27);
        result("log_one", 32'h8000_0000, 31, 1'b0);
        tick();

        accept(NORM_LOG, 32'h0000_1000);
        tick();
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.busy",  32'(busy), 32'd0);
        chk("midrst.done",  32'(done), 32'd0);
        chk("midrst.data",  o_data, 32'd0);
        chk("midrst.count", 32'(o_count), 32'd0);
        chk("midrst.zero",  32'(zero), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.after_busy", 32'(busy), 32'd0);
        chk("midrst.after_done", 32'(done), 32'd0);
        accept(NORM_LOG, 32'h0100_0000);
        run("log_0100", 8, 7);
        result("log_0100", 32'h8000_0000, 7, 1'b0);

        // New request presented during DONE goes straight back to SHIFT.
        start   = 1'b1;
        mode    = NORM_LOG;
        data_in = 32'h4000_0000;
        tick();
        start   = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.done", 32'(done), 32'd0);
        run("b2b", 2, 1);
        result("b2b", 32'h8000_0000, 1, 1'b0);
        idle_hold("b2b", 32'h8000_0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
